c17_bist_ctrl: RTL
==================

# c17_bist_ctrl

Built-in self-test initiator for the c17 combinational benchmark core. On `start` it drives test patterns onto the core's five inputs (N1, N2, N3, N6, N7) and compacts the returned N22/N23 responses into a 16-bit MISR signature. It compares the final signature against a golden value and reports pass/fail. It sits beside the core under test and is its only stimulus source in BIST builds.

## Interface
- `NUM_PATTERNS`, default 32: patterns applied per run, legal range 1..1024.
- `CUT_LAT`, default 0: pipeline depth of the core's response path, 0..3 cycles.
- `MISR_SEED`, default 16'h0000: MISR value loaded at run start.
- `LFSR_SEED`, default 5'h01: LFSR value loaded at run start; must be nonzero.
- `GOLDEN_SIG`, default 16'h0000: expected final signature.
- `CK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a run; ignored unless in IDLE or DONE.
- `mode`  in  1  0 = exhaustive counter patterns, 1 = LFSR patterns; sampled on accepted `start`.
- `pat_o`  out  5  pattern to the core: bit4=N1, bit3=N2, bit2=N3, bit1=N6, bit0=N7.
- `rsp_i`  in  2  response from the core: bit1=N22, bit0=N23.
- `busy`  out  1  high in APPLY and DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done` is high: signature == GOLDEN_SIG.
- `signature`  out  16  current MISR value.

## Operation
- States are IDLE, APPLY, DRAIN and DONE.
- IDLE: on `start`, enter APPLY.
  - Load the pattern generator: counter=0, or LFSR=LFSR_SEED.
  - Load MISR=MISR_SEED.
  - Load pattern index=0 and latch `mode`.
- APPLY: `pat_o` shows pattern k during the k-th APPLY cycle. The generator advances every cycle.
  - After NUM_PATTERNS cycles, go to DRAIN if CUT_LAT>0, otherwise go to DONE.
- DRAIN: hold `pat_o` at the last pattern for CUT_LAT cycles, then go to DONE.
- DONE: `done`=1 and `signature` is held. `start` begins a new run directly from DONE.
- Counter mode: pattern = index mod 32, giving 00, 01, …, 1F, 00, …
- LFSR mode: 5-bit Fibonacci LFSR, next = {l[3:0], l[4]^l[1]}, period 31, never zero.
  - From seed 01 the sequence is 01, 02, 05, 0A, 15, 0B, …
  - Wraps freely when NUM_PATTERNS > 31.
- MISR update: m' = {m[14:0],1'b0} ^ (m[15] ? 16'h100B : 16'h0) ^ {14'b0, rsp_i}.
- Valid-response qualification: a CUT_LAT+1-deep valid shift register is fed 1 in APPLY and 0 otherwise.
  - The MISR updates only when the tap at position CUT_LAT is 1.
  - With CUT_LAT=0 the MISR samples `rsp_i` on the same edge that ends pattern k.
- Total MISR updates per run are exactly NUM_PATTERNS.
- `pass` is a registered compare, updated on entry to DONE.

## Timing
- Reset values: state=IDLE, `pat_o`=5'h00, `busy`=0, `done`=0, `pass`=0, `signature`=MISR_SEED, LFSR=LFSR_SEED, valid pipe cleared.
- `RST` asserted mid-run aborts the run on the next edge and restores the reset values. No partial result is reported.
- `start` accepted at edge t: `busy`=1 and `pat_o`=pattern 0 from t+1.
- Run length: `done` rises NUM_PATTERNS+CUT_LAT cycles after `busy` rises.
- `busy` and `done` are never high together.
- `start` during APPLY or DRAIN has no effect.
- `start` in DONE: `done` drops and `busy` rises on the same edge, and MISR reloads.
- `RST` and `start` high in the same cycle: `RST` wins.
- `signature` changes only on qualified MISR updates, on run start, or on reset.

## Structure
- Shared package `c17_bist_pkg` holds:
  - state enum;
  - MISR polynomial 16'h100B and width 16;
  - LFSR width 5 and tap positions;
  - pin-order constants mapping `pat_o`/`rsp_i` bits to N-names.
- One sub-module, `c17_bist_misr`: the parameterised MISR with seed-load and enable.
- FSM, generators and compare stay in `c17_bist_ctrl`.
- Index counter width is $clog2(NUM_PATTERNS+1).

## Test plan
- Counter mode, NUM_PATTERNS=32, CUT_LAT=0, bench holds `rsp_i`=2'b00 -> `pat_o` steps 00..1F, `done` after 32 cycles, `signature`=16'h0000, `pass`=1 with GOLDEN_SIG=0.
- NUM_PATTERNS=2, `rsp_i`=2'b01 constant -> `signature` 0001 after first update, 0003 final.
- LFSR mode, seed 01 -> `pat_o` sequence 01, 02, 05, 0A, 15, 0B; value 00 never appears over 40 patterns.
- Real c17 model attached, CUT_LAT=2 with a 2-stage response register -> `done` at cycle 34, and `signature` equals the software model; flipping one response bit yields `pass`=0.
- `RST` asserted at pattern 10 -> next cycle IDLE, `pat_o`=00, `signature`=MISR_SEED; `start` during APPLY is ignored, with no pattern restart.
- `start` while in DONE -> `done` falls and `busy` rises on the same edge; second run reproduces an identical signature.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// Shared definitions for the c17 BIST initiator: FSM states, MISR and LFSR
// geometry, and the mapping of pattern/response bits to c17 pin names.
package c17_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam int              MISR_W    = 16;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h100B;

    localparam int LFSR_W      = 5;
    localparam int LFSR_TAP_HI = 4;
    localparam int LFSR_TAP_LO = 1;

    // Pattern bit positions on pat_o
    localparam int PAT_W  = 5;
    localparam int PIN_N1 = 4;
    localparam int PIN_N2 = 3;
    localparam int PIN_N3 = 2;
    localparam int PIN_N6 = 1;
    localparam int PIN_N7 = 0;

    // Response bit positions on rsp_i
    localparam int RSP_W   = 2;
    localparam int RSP_N22 = 1;
    localparam int RSP_N23 = 0;

    // Fibonacci step: shift left, feed back the XOR of the two taps.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], l[LFSR_TAP_HI] ^ l[LFSR_TAP_LO]};
    endfunction

    // Place a generator word (MSB = N1 ... LSB = N7) onto the core pins.
    function automatic logic [PAT_W-1:0] to_pins(input logic [PAT_W-1:0] p);
        logic [PAT_W-1:0] o;
        o         = '0;
        o[PIN_N1] = p[4];
        o[PIN_N2] = p[3];
        o[PIN_N3] = p[2];
        o[PIN_N6] = p[1];
        o[PIN_N7] = p[0];
        return o;
    endfunction

endpackage

// File: rtl/c17_bist_misr.sv
// Multiple-input signature register with seed load and update enable.
// sig_next is exported so the caller can judge the final signature on the
// same edge that produces it.
module c17_bist_misr
    import c17_bist_pkg::*;
#(
    parameter int             W     = MISR_W,
    parameter int             DIN_W = RSP_W,
    parameter logic [W-1:0]   POLY  = MISR_POLY,
    parameter logic [W-1:0]   SEED  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [W-1:0]     sig,
    output logic [W-1:0]     sig_next
);

    logic [W-1:0] step;

    // Next signature: load beats update, otherwise hold.
    always_comb begin
        step = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ {{(W-DIN_W){1'b0}}, din};
        if (load) begin
            sig_next = SEED;
        end else if (en) begin
            sig_next = step;
        end else begin
            sig_next = sig;
        end
    end

    // Signature register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= SEED;
        end else begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST initiator for the c17 core: generates counter or LFSR patterns,
// compacts responses into a MISR after the core latency, and compares the
// final signature against a golden value.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int          NUM_PATTERNS = 32,
    parameter int          CUT_LAT      = 0,
    parameter logic [15:0] MISR_SEED    = 16'h0000,
    parameter logic [4:0]  LFSR_SEED    = 5'h01,
    parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    input  logic        mode,
    output logic [4:0]  pat_o,
    input  logic [1:0]  rsp_i,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int              IDX_W      = $clog2(NUM_PATTERNS + 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_PATTERNS - 1);
    localparam logic [1:0]      DRAIN_LAST = (CUT_LAT > 0) ? 2'(CUT_LAT - 1) : 2'd0;

    bist_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [4:0]         cnt_q;
    logic [LFSR_W-1:0]  lfsr_q;
    logic               mode_q;
    logic [1:0]         drain_q;
    logic               pass_q;
    logic               start_run;
    logic               in_apply;
    logic               vld_tap;
    logic [MISR_W-1:0]  misr_next;
    logic [PAT_W-1:0]   pat_cur;

    assign in_apply = (state_q == ST_APPLY);

    // Next-state logic; start_run marks an accepted start.
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_d   = ST_APPLY;
                end
            end
            ST_APPLY: begin
                if (idx_q == IDX_LAST) begin
                    state_d = (CUT_LAT > 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, generators, drain counter and registered pass flag. The
    // generators stop on the last pattern so DRAIN keeps showing it.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            mode_q  <= 1'b0;
            drain_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_run) begin
                idx_q   <= '0;
                cnt_q   <= '0;
                lfsr_q  <= LFSR_SEED;
                mode_q  <= mode;
                drain_q <= '0;
                pass_q  <= 1'b0;
            end else begin
                if (in_apply && (idx_q != IDX_LAST)) begin
                    idx_q  <= idx_q + 1'b1;
                    cnt_q  <= cnt_q + 1'b1;
                    lfsr_q <= lfsr_next(lfsr_q);
                end
                if (state_q == ST_DRAIN) begin
                    drain_q <= drain_q + 1'b1;
                end
                if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
                    pass_q <= (misr_next == GOLDEN_SIG);
                end
            end
        end
    end

    // Response-valid qualification: tap 0 is the APPLY cycle itself, each
    // further tap delays it by one cycle to match the core latency.
    generate
        if (CUT_LAT == 0) begin : g_no_pipe
            assign vld_tap = in_apply;
        end else begin : g_pipe
            logic [CUT_LAT-1:0] vpipe_q;
            // Valid shift register, cleared on reset.
            always_ff @(posedge CK) begin
                if (RST) begin
                    vpipe_q <= '0;
                end else begin
                    vpipe_q[0] <= in_apply;
                    for (int i = 1; i < CUT_LAT; i++) begin
                        vpipe_q[i] <= vpipe_q[i-1];
                    end
                end
            end
            assign vld_tap = vpipe_q[CUT_LAT-1];
        end
    endgenerate

    c17_bist_misr #(
        .W     (MISR_W),
        .DIN_W (RSP_W),
        .POLY  (MISR_POLY),
        .SEED  (MISR_SEED)
    ) u_misr (
        .clk      (CK),
        .rst      (RST),
        .load     (start_run),
        .en       (vld_tap),
        .din      ({rsp_i[RSP_N22], rsp_i[RSP_N23]}),
        .sig      (signature),
        .sig_next (misr_next)
    );

    assign pat_cur = mode_q ? lfsr_q : cnt_q;
    assign busy    = (state_q == ST_APPLY) || (state_q == ST_DRAIN);
    assign done    = (state_q == ST_DONE);
    assign pass    = pass_q;
    assign pat_o   = busy ? to_pins(pat_cur) : '0;

endmodule
